// File: rtl/collision_detector.sv
// Pixel-rate player/obstacle overlap detector: one collision pulse per frame, masked
// while the player recovers. Define COLL_GRACE_EN to add a post-recovery GRACE window.
module collision_detector #(
    parameter int NUM_ENEMIES  = 4,
    parameter int CNT_W        = 8,
    parameter int GRACE_FRAMES = 30
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   startOfFrame,
    input  logic                   playerDR,
    input  logic [NUM_ENEMIES-1:0] enemyDR,
    input  logic                   borderDR,
    input  logic                   playerRecover,
    output logic                   collision,
    output logic [3:0]             hitSource,
    output logic [CNT_W-1:0]       hitCount,
    output logic                   detectorBusy
);

    typedef enum logic [2:0] {
        ARMED,
        PULSE,
        MASKED,
        RECOVERY
`ifdef COLL_GRACE_EN
        , GRACE
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       src_q, src_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       hit_src;
    logic             overlap;

`ifdef COLL_GRACE_EN
    localparam int GCNT_W = (GRACE_FRAMES > 1) ? $clog2(GRACE_FRAMES) : 1;
    logic [GCNT_W-1:0] gcnt_q, gcnt_d;
`endif

    assign overlap = playerDR & (borderDR | (|enemyDR));

    // Border outranks enemies; among enemies the lowest index wins.
    always_comb begin
        hit_src = '0;
        if (borderDR) begin
            hit_src = 4'b1000;
        end else begin
            for (int i = NUM_ENEMIES - 1; i >= 0; i--) begin
                if (enemyDR[i]) hit_src = {1'b0, 3'(i)};
            end
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        cnt_d   = cnt_q;
`ifdef COLL_GRACE_EN
        gcnt_d  = gcnt_q;
`endif
        case (state_q)
            ARMED: begin
                if (overlap) begin
                    if (!playerRecover) begin
                        state_d = PULSE;
                        src_d   = hit_src;
                        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                    end else begin
                        state_d = RECOVERY;
                    end
                end
            end
            PULSE:  state_d = MASKED;
            MASKED: begin
                if (startOfFrame) state_d = playerRecover ? RECOVERY : ARMED;
            end
            RECOVERY: begin
                if (startOfFrame && !playerRecover) begin
`ifdef COLL_GRACE_EN
                    state_d = GRACE;
                    gcnt_d  = '0;
`else
                    state_d = ARMED;
`endif
                end
            end
`ifdef COLL_GRACE_EN
            // The RECOVERY->GRACE frame is the first ignored frame.
            GRACE: begin
                if (startOfFrame) begin
                    if (gcnt_q == GCNT_W'(GRACE_FRAMES - 1)) state_d = ARMED;
                    else gcnt_d = gcnt_q + 1'b1;
                end
            end
`endif
            default: state_d = ARMED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARMED;
            src_q   <= '0;
            cnt_q   <= '0;
`ifdef COLL_GRACE_EN
            gcnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            cnt_q   <= cnt_d;
`ifdef COLL_GRACE_EN
            gcnt_q  <= gcnt_d;
`endif
        end
    end

    // Gated by reset so a pulse in flight is cut in the reset cycle itself.
    assign collision    = (state_q == PULSE) && !reset;
    assign hitSource    = src_q;
    assign hitCount     = cnt_q;
    assign detectorBusy = (state_q != ARMED);

endmodule

// File: tb/tb_collision_detector.sv
// Directed bench for collision_detector (CNT_W=2, GRACE_FRAMES=2); honours COLL_GRACE_EN.
module tb_collision_detector;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       startOfFrame = 1'b0;
    logic       playerDR = 1'b0;
    logic [3:0] enemyDR = 4'b0;
    logic       borderDR = 1'b0;
    logic       playerRecover = 1'b0;
    logic       collision;
    logic [3:0] hitSource;
    logic [1:0] hitCount;
    logic       detectorBusy;

    int n_cmp = 0;
    int n_bad = 0;

    collision_detector #(.NUM_ENEMIES(4), .CNT_W(2), .GRACE_FRAMES(2)) dut (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .playerDR(playerDR),
        .enemyDR(enemyDR), .borderDR(borderDR), .playerRecover(playerRecover),
        .collision(collision), .hitSource(hitSource), .hitCount(hitCount),
        .detectorBusy(detectorBusy)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic p, input logic [3:0] e, input logic b, input logic s);
        playerDR = p; enemyDR = e; borderDR = b; startOfFrame = s;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 4'b0, 0, 0);
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic sof();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (collision !== 1'b0) begin n_bad++; $display("FAIL reset_coll got %b exp 0", collision); end
        n_cmp++; if (hitSource !== 4'b0) begin n_bad++; $display("FAIL reset_src got %b exp 0000", hitSource); end
        n_cmp++; if (hitCount !== 2'd0) begin n_bad++; $display("FAIL reset_cnt got %0d exp 0", hitCount); end
        n_cmp++; if (detectorBusy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b exp 0", detectorBusy); end
    endtask

    task automatic test_no_overlap();
        drive(1, 4'b0, 0, 0); tick(); drive(0, 4'b0, 0, 0);
        n_cmp++; if (collision !== 1'b0) begin n_bad++; $display("FAIL noov_coll got %b exp 0", collision); end
        n_cmp++; if (detectorBusy !== 1'b0) begin n_bad++; $display("FAIL noov_busy got %b exp 0", detectorBusy); end
        drive(0, 4'b1111, 1, 0); tick(); drive(0, 4'b0, 0, 0);
        n_cmp++; if (collision !== 1'b0) begin n_bad++; $display("FAIL noplayer_coll got %b exp 0", collision); end
    endtask

    task automatic test_enemy_hit();
        drive(1, 4'b0100, 0, 0); tick(); drive(0, 4'b0, 0, 0);
        n_cmp++; if (collision !== 1'b1) begin n_bad++; $display("FAIL t1_coll got %b exp 1", collision); end
        n_cmp++; if (hitSource !== 4'b0010) begin n_bad++; $display("FAIL t1_src got %b exp 0010", hitSource); end
        n_cmp++; if (hitCount !== 2'd1) begin n_bad++; $display("FAIL t1_cnt got %0d exp 1", hitCount); end
        n_cmp++; if (detectorBusy !== 1'b1) begin n_bad++; $display("FAIL t1_busy got %b exp 1", detectorBusy); end
        tick();
        n_cmp++; if (collision !== 1'b0) begin n_bad++; $display("FAIL t1_coll_low got %b exp 0", collision); end
        n_cmp++; if (detectorBusy !== 1'b1) begin n_bad++; $display("FAIL t1_masked_busy got %b exp 1", detectorBusy); end
        sof();
        n_cmp++; if (detectorBusy !== 1'b0) begin n_bad++; $display("FAIL t1_rearm got %b exp 0", detectorBusy); end
    endtask

    task automatic test_border_priority();
        drive(1, 4'b0001, 1, 0); tick(); drive(0, 4'b0, 0, 0);
        n_cmp++; if (collision !== 1'b1) begin n_bad++; $display("FAIL t2_coll got %b exp 1", collision); end
        n_cmp++; if (hitSource !== 4'b1000) begin n_bad++; $display("FAIL t2_src got %b exp 1000", hitSource); end
        n_cmp++; if (hitCount !== 2'd2) begin n_bad++; $display("FAIL t2_cnt got %0d exp 2", hitCount); end
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 4'b0010, 0, 0); tick(); drive(0, 4'b0, 0, 0);
            n_cmp++; if (collision !== 1'b0) begin n_bad++; $display("FAIL t2_repeat%0d got %b exp 0", i, collision); end
        end
        n_cmp++; if (hitCount !== 2'd2) begin n_bad++; $display("FAIL t2_cnt_hold got %0d exp 2", hitCount); end
        n_cmp++; if (hitSource !== 4'b1000) begin n_bad++; $display("FAIL t2_src_hold got %b exp 1000", hitSource); end
        sof();
    endtask

    task automatic test_recovery();
        playerRecover = 1'b1;
        drive(1, 4'b0001, 0, 0); tick(); drive(0, 4'b0, 0, 0);
        n_cmp++; if (collision !== 1'b0) begin n_bad++; $display("FAIL t3_rec_coll got %b exp 0", collision); end
        n_cmp++; if (detectorBusy !== 1'b1) begin n_bad++; $display("FAIL t3_rec_busy got %b exp 1", detectorBusy); end
        for (int f = 0; f < 3; f++) begin
            sof();
            drive(1, 4'b0100, 0, 0); tick(); drive(0, 4'b0, 0, 0);
            n_cmp++; if (collision !== 1'b0) begin n_bad++; $display("FAIL t3_frame%0d got %b exp 0", f, collision); end
        end
        n_cmp++; if (hitCount !== 2'd2) begin n_bad++; $display("FAIL t3_cnt_hold got %0d exp 2", hitCount); end
        playerRecover = 1'b0;
        sof();
`ifdef COLL_GRACE_EN
        for (int f = 0; f < 2; f++) begin
            drive(1, 4'b0100, 0, 0); tick(); drive(0, 4'b0, 0, 0);
            n_cmp++; if (collision !== 1'b0) begin n_bad++; $display("FAIL t6_grace%0d got %b exp 0", f, collision); end
            n_cmp++; if (detectorBusy !== 1'b1) begin n_bad++; $display("FAIL t6_grace_busy%0d got %b exp 1", f, detectorBusy); end
            sof();
        end
`endif
        n_cmp++; if (detectorBusy !== 1'b0) begin n_bad++; $display("FAIL t3_armed got %b exp 0", detectorBusy); end
        drive(1, 4'b1010, 0, 0); tick(); drive(0, 4'b0, 0, 0);
        n_cmp++; if (collision !== 1'b1) begin n_bad++; $display("FAIL t3_pulse got %b exp 1", collision); end
        n_cmp++; if (hitSource !== 4'b0001) begin n_bad++; $display("FAIL t3_src got %b exp 0001", hitSource); end
        n_cmp++; if (hitCount !== 2'd3) begin n_bad++; $display("FAIL t3_cnt got %0d exp 3", hitCount); end
        tick();
        sof();
    endtask

    task automatic test_sof_overlap();
        drive(1, 4'b1000, 0, 1); tick(); drive(0, 4'b0, 0, 0);
        n_cmp++; if (collision !== 1'b1) begin n_bad++; $display("FAIL t4_coll got %b exp 1", collision); end
        n_cmp++; if (hitSource !== 4'b0011) begin n_bad++; $display("FAIL t4_src got %b exp 0011", hitSource); end
        n_cmp++; if (hitCount !== 2'd3) begin n_bad++; $display("FAIL t4_cnt_sat got %0d exp 3", hitCount); end
        startOfFrame = 1'b1; tick(); startOfFrame = 1'b0;
        n_cmp++; if (detectorBusy !== 1'b1) begin n_bad++; $display("FAIL t4_sof_in_pulse got %b exp 1", detectorBusy); end
        drive(1, 4'b0001, 0, 0); tick(); drive(0, 4'b0, 0, 0);
        n_cmp++; if (collision !== 1'b0) begin n_bad++; $display("FAIL t4_masked got %b exp 0", collision); end
        sof();
        n_cmp++; if (detectorBusy !== 1'b0) begin n_bad++; $display("FAIL t4_rearm got %b exp 0", detectorBusy); end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1, 4'b0010, 0, 0); tick(); drive(0, 4'b0, 0, 0);
            n_cmp++; if (collision !== 1'b1) begin n_bad++; $display("FAIL t5_coll%0d got %b exp 1", i, collision); end
            n_cmp++; if (hitCount !== exp_cnt[i]) begin n_bad++; $display("FAIL t5_cnt%0d got %0d exp %0d", i, hitCount, exp_cnt[i]); end
            tick();
            sof();
        end
    endtask

    task automatic test_reset_mid_pulse();
        drive(1, 4'b0001, 0, 0); tick(); drive(0, 4'b0, 0, 0);
        n_cmp++; if (collision !== 1'b1) begin n_bad++; $display("FAIL t6_pre got %b exp 1", collision); end
        reset = 1'b1;
        #1;
        n_cmp++; if (collision !== 1'b0) begin n_bad++; $display("FAIL t6_rst_coll got %b exp 0", collision); end
        tick();
        reset = 1'b0;
        n_cmp++; if (hitCount !== 2'd0) begin n_bad++; $display("FAIL t6_rst_cnt got %0d exp 0", hitCount); end
        n_cmp++; if (hitSource !== 4'b0) begin n_bad++; $display("FAIL t6_rst_src got %b exp 0000", hitSource); end
        n_cmp++; if (detectorBusy !== 1'b0) begin n_bad++; $display("FAIL t6_rst_busy got %b exp 0", detectorBusy); end
    endtask

    initial begin
        test_reset();
        test_no_overlap();
        test_enemy_hit();
        test_border_priority();
        test_recovery();
        test_sof_overlap();
        test_saturation();
        test_reset_mid_pulse();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
